// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch block.
//   - state_t    : fetch FSM states
//   - OPC_*      : position of the opcode field in a default-width instruction
//   - *_DEF      : default widths/depths used as module parameter defaults
package fetch_pkg;

    localparam int AW_DEF          = 10;
    localparam int IW_DEF          = 16;
    localparam int STACK_DEPTH_DEF = 4;

    // Opcode occupies the top six bits of the instruction word.
    localparam int OPC_W  = 6;
    localparam int OPC_HI = IW_DEF - 1;
    localparam int OPC_LO = IW_DEF - OPC_W;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for call/return.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset (empties the stack)
//   push, pop     : push push_data / drop the top entry (ignored when full / empty)
//   push_data     : address to save
//   top           : most recently pushed entry (undefined content when empty)
//   full, empty   : occupancy flags
// Entries are not cleared on pop or reset; only the pointer moves.
module ret_stack #(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [PW:0]   sp_reg;
    logic [PW-1:0] top_idx;

    assign full    = (sp_reg == (PW+1)'(DEPTH));
    assign empty   = (sp_reg == '0);
    // Low pointer bits minus one wraps naturally: sp==DEPTH gives DEPTH-1.
    assign top_idx = sp_reg[PW-1:0] - 1'b1;
    assign top     = mem[top_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_reg <= '0;
        end else if (push && !full) begin
            sp_reg <= sp_reg + 1'b1;
        end else if (pop && !empty) begin
            sp_reg <= sp_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp_reg[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and program counter.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   imem_req/imem_addr    : fetch request (held until ack) and address (= PC)
//   imem_ack/imem_rdata   : memory response, sampled at posedge while requesting
//   s_inc, s_call, s_ret  : next-PC selects from the control unit, used in EXEC only
//   Opcode, instr         : instruction register fields
//   exec                  : one-cycle execute strobe
//   stack_err             : sticky stack overflow/underflow/conflict flag
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int IW          = IW_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    input  logic          s_inc,
    input  logic          s_call,
    input  logic          s_ret,
    output logic [5:0]    Opcode,
    output logic [IW-1:0] instr,
    output logic          exec,
    output logic          stack_err
);

    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [IW-1:0] ir_reg, ir_next;
    logic          req_reg, req_next;
    logic          exec_reg, exec_next;
    logic          err_reg, err_next;

    logic          push, pop;
    logic          stk_full, stk_empty;
    logic [AW-1:0] stk_top;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] target;

    assign pc_inc = pc_reg + 1'b1;      // wraps modulo 2^AW
    assign target = ir_reg[AW-1:0];

    ret_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
            req_reg   <= 1'b0;
            exec_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            req_reg   <= req_next;
            exec_reg  <= exec_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        req_next   = req_reg;
        exec_next  = exec_reg;
        err_next   = err_reg;
        push       = 1'b0;
        pop        = 1'b0;

        case (state_reg)
            FETCH: begin
                // An ack only counts against a request already on the bus;
                // right after reset req_reg is still low and the ack is dropped.
                if (req_reg && imem_ack) begin
                    ir_next    = imem_rdata;
                    req_next   = 1'b0;
                    exec_next  = 1'b1;
                    state_next = EXEC;
                end else begin
                    req_next = 1'b1;
                end
            end
            EXEC: begin
                // Request goes straight back up so the next fetch can be
                // acked in its first cycle (2 cycles per instruction).
                state_next = FETCH;
                exec_next  = 1'b0;
                req_next   = 1'b1;
                if (s_call && s_ret) begin
                    pc_next  = pc_inc;
                    err_next = 1'b1;
                end else if (s_call) begin
                    if (stk_full) err_next = 1'b1;
                    else          push     = 1'b1;
                    pc_next = target;
                end else if (s_ret) begin
                    if (stk_empty) begin
                        pc_next  = pc_inc;
                        err_next = 1'b1;
                    end else begin
                        pc_next = stk_top;
                        pop     = 1'b1;
                    end
                end else if (s_inc) begin
                    pc_next = pc_inc;
                end else begin
                    pc_next = target;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    assign imem_req  = req_reg;
    assign imem_addr = pc_reg;
    assign instr     = ir_reg;
    assign Opcode    = ir_reg[IW-1 -: OPC_W];
    assign exec      = exec_reg;
    assign stack_err = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers fetches, a small
// control-unit model decodes Opcode into next-PC selects, and a monitor
// compares every fetch address / instruction against queued expectations.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW = 10;
    localparam int IW = 16;

    localparam logic [5:0] OP_JMP  = 6'h02;
    localparam logic [5:0] OP_CALL = 6'h03;
    localparam logic [5:0] OP_RET  = 6'h04;
    localparam logic [5:0] OP_CONF = 6'h05;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          s_inc = 1'b0, s_call = 1'b0, s_ret = 1'b0;
    logic [5:0]    Opcode;
    logic [IW-1:0] instr;
    logic          exec;
    logic          stack_err;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .s_inc      (s_inc),
        .s_call     (s_call),
        .s_ret      (s_ret),
        .Opcode     (Opcode),
        .instr      (instr),
        .exec       (exec),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] imem [0:1023];
    int            delay_cyc = 0;
    bit            force_ack = 1'b0;
    bit            check_wait = 1'b0;
    bit            mon_en = 1'b0;
    int            wcnt = 0;

    logic [AW-1:0] exp_q [$];
    logic [IW-1:0] exp_i [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] w(input logic [5:0] op, input logic [AW-1:0] tgt);
        return {op, tgt};
    endfunction

    task automatic exp_add(input int a);
        exp_q.push_back(AW'(a));
    endtask

    // Memory model: acks after delay_cyc extra request cycles.
    always @(negedge clk) begin
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = imem[imem_addr];
        end else if (imem_req) begin
            imem_ack   = (wcnt >= delay_cyc);
            imem_rdata = imem[imem_addr];
            wcnt++;
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    end

    // Control-unit model: decodes Opcode during exec; drives junk otherwise.
    always @(negedge clk) begin
        if (exec) begin
            case (Opcode)
                OP_JMP:  {s_inc, s_call, s_ret} = 3'b000;
                OP_CALL: {s_inc, s_call, s_ret} = 3'b010;
                OP_RET:  {s_inc, s_call, s_ret} = 3'b001;
                OP_CONF: {s_inc, s_call, s_ret} = 3'b011;
                default: {s_inc, s_call, s_ret} = 3'b100;
            endcase
        end else begin
            {s_inc, s_call, s_ret} = 3'b011;
        end
    end

    // Monitor / scoreboard.
    bit            prev_acc = 1'b0;
    bit            prev_exec = 1'b0;
    bit            acc;
    int            reqcnt = 0;
    logic [AW-1:0] m_addr;
    logic [IW-1:0] m_word;

    always @(negedge clk) begin
        #2;
        if (!mon_en) begin
            prev_acc  = 1'b0;
            prev_exec = 1'b0;
            reqcnt    = 0;
        end else begin
            chk("exec_pulse", 32'(exec), 32'(prev_acc));
            if (prev_exec) chk("req_after_exec", 32'(imem_req), 32'd1);
            if (imem_req) begin
                reqcnt++;
                if (exp_q.size() > 0) chk("fetch_addr", 32'(imem_addr), 32'(exp_q[0]));
            end
            acc = imem_req && imem_ack;
            if (acc) begin
                if (exp_q.size() > 0) begin
                    m_addr = exp_q.pop_front();
                    exp_i.push_back(imem[m_addr]);
                    if (check_wait) chk("req_cycles", 32'(reqcnt), 32'(delay_cyc + 1));
                    $display("fetch addr=%03h word=%04h", m_addr, imem[m_addr]);
                end
                reqcnt = 0;
            end
            if (exec && exp_i.size() > 0) begin
                m_word = exp_i.pop_front();
                chk("instr", 32'(instr), 32'(m_word));
                chk("opcode", 32'(Opcode), 32'(m_word[OPC_HI:OPC_LO]));
            end
            prev_acc  = acc;
            prev_exec = exec;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) imem[i] = '0;
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        force_ack = 1'b0;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_exec", 32'(exec), 32'd0);
        chk("rst_err", 32'(stack_err), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("req_first_cycle", 32'(imem_req), 32'd0);
        mon_en = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() > 0 || exp_i.size() > 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0 || exp_i.size() > 0) begin
            errors++;
            $display("FAIL timeout pending=%0d expected=0", exp_q.size() + exp_i.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // 1: single-cycle ack, sequential
        clear_mem();
        exp_add(0); exp_add(1); exp_add(2); exp_add(3);
        delay_cyc = 0; check_wait = 1'b1;
        do_reset();
        wait_done();

        // 2: three-cycle ack delay
        clear_mem();
        exp_add(0); exp_add(1);
        delay_cyc = 3; check_wait = 1'b1;
        do_reset();
        wait_done();

        // 3: jumps and PC wrap
        clear_mem();
        imem[0]     = w(OP_JMP, 10'h005);
        imem[5]     = w(OP_JMP, 10'h3F0);
        imem[10'h3F0] = w(OP_JMP, 10'h3FF);
        exp_add(0); exp_add(5); exp_add(10'h3F0); exp_add(10'h3FF); exp_add(0);
        delay_cyc = 0; check_wait = 1'b1;
        do_reset();
        wait_done();

        // 4: call / return
        clear_mem();
        imem[0]  = w(OP_JMP, 10'd7);
        imem[7]  = w(OP_CALL, 10'd20);
        imem[22] = w(OP_RET, 10'd0);
        exp_add(0); exp_add(7); exp_add(20); exp_add(21); exp_add(22); exp_add(8);
        delay_cyc = 1; check_wait = 1'b1;
        do_reset();
        wait_done();
        chk("err_after_call_ret", 32'(stack_err), 32'd0);

        // 5: overflow then underflow
        clear_mem();
        imem[0]  = w(OP_CALL, 10'd10);
        imem[10] = w(OP_CALL, 10'd20);
        imem[20] = w(OP_CALL, 10'd30);
        imem[30] = w(OP_CALL, 10'd40);
        imem[40] = w(OP_CALL, 10'd50);
        imem[50] = w(OP_RET, 10'd0);
        imem[31] = w(OP_RET, 10'd0);
        imem[21] = w(OP_RET, 10'd0);
        imem[11] = w(OP_RET, 10'd0);
        imem[1]  = w(OP_RET, 10'd0);
        exp_add(0); exp_add(10); exp_add(20); exp_add(30); exp_add(40);
        exp_add(50); exp_add(31); exp_add(21); exp_add(11); exp_add(1); exp_add(2);
        delay_cyc = 0; check_wait = 1'b1;
        do_reset();
        wait_done();
        chk("err_overflow", 32'(stack_err), 32'd1);

        // 7: call+ret conflict
        clear_mem();
        imem[0] = w(OP_CONF, 10'd9);
        exp_add(0); exp_add(1); exp_add(2);
        delay_cyc = 0; check_wait = 1'b1;
        do_reset();
        wait_done();
        chk("err_conflict", 32'(stack_err), 32'd1);

        // 6: reset while a fetch is stalled, ack driven during reset
        clear_mem();
        imem[0] = w(OP_CALL, 10'd4);
        delay_cyc = 20; check_wait = 1'b0;
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("req_stalled", 32'(imem_req), 32'd1);
        #2;
        mon_en    = 1'b0;
        reset     = 1'b0;
        force_ack = 1'b1;
        #1;
        chk("req_async_drop", 32'(imem_req), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        imem[0] = '0;
        reset = 1'b1;
        #1;
        chk("req_after_release", 32'(imem_req), 32'd0);
        chk("addr_after_release", 32'(imem_addr), 32'd0);
        exp_add(0); exp_add(1);
        mon_en = 1'b1;
        wait_done();
        chk("err_after_reset", 32'(stack_err), 32'd0);
        force_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and program-counter block; the producing end of the control-unit interface.
- Fetches instruction words from instruction memory over a req/ack handshake and holds them in an instruction register.
- Drives Opcode and the instruction fields to the control unit and datapath.
- Consumes the control unit's next-PC selects (s_inc, plus call/return) to compute the next PC; includes a small return-address stack.

Parameters:
AW, 10, PC / instruction-memory address width
IW, 16, instruction word width; Opcode = instr[IW-1:IW-6], jump target = instr[AW-1:0]
STACK_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request, held high until ack
imem_addr  out  AW  fetch address, equals PC while imem_req high
imem_ack  in  1  memory response valid; sampled at posedge
imem_rdata  in  IW  instruction word, valid with imem_ack
s_inc  in  1  1: next PC = PC+1; 0: next PC = jump target
s_call  in  1  push PC+1, jump to target
s_ret  in  1  pop return address into PC
Opcode  out  6  opcode field of the instruction register
instr  out  IW  full instruction register
exec  out  1  high for exactly the execute cycle; datapath gates we/wez with it
stack_err  out  1  sticky overflow/underflow/conflict flag

Behaviour:
- Reset (reset=0, asynchronous): PC=0, IR=0, state=FETCH, imem_req=0, exec=0, stack empty (sp=0), stack_err=0.
  - imem_req stays 0 during reset and in the first cycle after reset release.
  - It rises on the first posedge with reset=1.
- FSM states FETCH, EXEC.
  - FETCH: imem_req=1, imem_addr=PC.
  - On a posedge with imem_ack=1: IR<=imem_rdata, imem_req<=0, go to EXEC.
  - Without ack, stay in FETCH with PC held.
  - An ack arriving while imem_req=0 is ignored.
- EXEC: exec=1 for one cycle; Opcode/instr stable for the whole cycle, so the control unit can settle on negedge.
  - At the end of the cycle (next posedge), the PC update below applies, then the FSM returns to FETCH.
- Throughput: minimum 2 cycles per instruction (ack in the first FETCH cycle); each extra ack-wait cycle adds 1.
- PC update in EXEC, priority order:
  1. s_call=1 and s_ret=1: conflict; PC<=PC+1, stack unchanged, stack_err<=1.
  2. s_call=1: if sp<STACK_DEPTH, push (PC+1) mod 2^AW, sp+1; if full, no push, stack_err<=1. PC<=target either way.
  3. s_ret=1: if sp>0, PC<=top, sp-1; if empty, PC<=PC+1, stack_err<=1.
  4. s_inc=1: PC<=PC+1.
  5. else: PC<=instr[AW-1:0].
- Selects are sampled only in EXEC; they are ignored in FETCH.
- Arithmetic: PC+1 wraps modulo 2^AW (2^AW-1 -> 0).
- Stack: LIFO; sp ranges 0..STACK_DEPTH; entries are not cleared on pop.
- stack_err clears only on reset.
- Reset mid-fetch: imem_req drops immediately (asynchronously); any in-flight ack after release is ignored until a new request is issued.
- Outputs are registered except imem_addr, which equals PC combinationally.

Decomposition:
- Package fetch_pkg:
  - state enum {FETCH, EXEC}
  - opcode field position constants (OPC_HI, OPC_LO)
  - default width constants
- Sub-module ret_stack (push, pop, full, empty, top; STACK_DEPTH x AW; same clk/reset); fetch_unit instantiates it.

Test Plan:
1. Release reset; memory acks every request in 1 cycle; s_inc=1 always -> imem_addr 0,1,2,3; exec pulses every 2nd cycle; Opcode equals rdata[15:10].
2. Memory delays ack 3 cycles -> imem_req high 4 cycles with imem_addr constant; exactly one exec pulse; PC unchanged until EXEC.
3. Instruction at 5 with s_inc=0, target 0x3F0 -> next imem_addr=0x3F0. At PC=0x3FF with s_inc=1 -> next imem_addr=0x000.
4. s_call at PC=7 to target 20, then s_ret at PC=22 -> fetch sequence 7, 20, 21, 22, 8; stack_err=0.
5. Five nested calls with STACK_DEPTH=4 -> 5th call still jumps, stack_err=1. Then five returns -> the 5th return goes to PC+1; first four return addresses are in LIFO order.
6. Assert reset while in FETCH with imem_req=1, and drive ack during reset -> imem_req=0 immediately; after release PC=0 and first fetch address is 0; stack_err=0.
